yc_wrr_arbiter: RTL

- Parametrised N-input weighted round-robin output arbiter for the yc NoC router; it generalises the router's fixed 3-way fair arbitration.
- Sits between the per-input buffers and one output port, with one instance per output.
- Adds per-input programmable weights, multi-flit packet locking and per-input grant statistics.
- With all weights equal to 1 it must reproduce strict round-robin fairness: delivered counts of continuously-requesting inputs differ by at most 1.

---
 rtl/yc_noc_defs.sv | 46 ++++
 rtl/yc_wrr_arbiter_pick.sv | 26 ++
 rtl/yc_wrr_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/yc_noc_defs.sv
// Shared yc NoC router types: flit layout, arbiter state encoding and the
// wrap-around first-set finder used by the output arbiters.
package yc_noc_defs;

   localparam int RR_MAX = 16;

   typedef struct packed {
      logic [3:0]  src;
      logic [27:0] payload;
   } flit_t;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   function automatic flit_t mk_flit(input logic [3:0] src, input logic [27:0] payload);
      flit_t f;
      f.src     = src;
      f.payload = payload;
      return f;
   endfunction

   function automatic logic [3:0] flit_src(input flit_t f);
      return f.src;
   endfunction

   function automatic logic [27:0] flit_payload(input flit_t f);
      return f.payload;
   endfunction

   // First set index at or after start (wrapping modulo n); -1 when req is empty.
   // Walks offsets from far to near so the nearest hit is the one kept.
   function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int start, input int n);
      int j;
      int idx;
      idx = -1;
      for (int k = n - 1; k >= 0; k--) begin
         j = start + k;
         if (j >= n) j = j - n;
         if (req[j[3:0]]) idx = j;
      end
      return idx;
   endfunction

endpackage

// File: rtl/yc_wrr_arbiter_pick.sv
// Combinational rotating priority finder: first requester at or after i_start.
module yc_rr_pick
   import yc_noc_defs::*;
#(
   parameter int N  = 5,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_start,
   output logic [IW-1:0] o_idx,
   output logic          o_found
);

   logic [RR_MAX-1:0] w_req;
   int                w_pick;

   always_comb begin
      w_req        = '0;
      w_req[N-1:0] = i_req;
      w_pick       = rr_pick(w_req, int'(i_start), N);
   end

   assign o_found = (w_pick >= 0);
   assign o_idx   = w_pick[IW-1:0];

endmodule

// File: rtl/yc_wrr_arbiter.sv
// Weighted round-robin output arbiter with packet locking and per-input
// saturating packet counters; datapath is a zero-latency mux.
module yc_wrr_arbiter
   import yc_noc_defs::*;
#(
   parameter int N_IN = 5,
   parameter int WW   = 4,
   parameter int CW   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_IN-1:0]            in_valid,
   input  flit_t [N_IN-1:0]           in_flit,
   input  logic [N_IN-1:0]            in_last,
   output logic [N_IN-1:0]            in_ready,
   output logic                       out_valid,
   output flit_t                      out_flit,
   input  logic                       out_ready,
   input  logic [N_IN*WW-1:0]         weight,
   input  logic                       stat_clr,
   output logic [N_IN*CW-1:0]         stat_cnt,
   output logic [$clog2(N_IN)-1:0]    cur_grant
);

   localparam int IW = $clog2(N_IN);

   arb_state_e    r_state, w_state_nxt;
   logic [IW-1:0] r_ptr, w_ptr_nxt;
   logic [IW-1:0] r_owner, w_owner_nxt;
   logic [WW-1:0] r_credit, w_credit_nxt;
   logic [IW-1:0] w_ptr_inc, w_start, w_pick, w_sel;
   logic [WW-1:0] w_wsel;
   logic          w_found, w_xfer, w_done;
   logic [CW-1:0] r_stat [N_IN];

   // Spent quota: ptr itself is considered last.
   assign w_ptr_inc = (r_ptr == IW'(N_IN - 1)) ? '0 : r_ptr + IW'(1);
   assign w_start   = (r_credit != '0) ? r_ptr : w_ptr_inc;

   yc_rr_pick #(.N(N_IN), .IW(IW)) u_pick (
      .i_req   (in_valid),
      .i_start (w_start),
      .o_idx   (w_pick),
      .o_found (w_found)
   );

   assign w_sel     = (r_state == LOCK) ? r_owner : (w_found ? w_pick : r_ptr);
   assign out_valid = in_valid[w_sel];
   assign out_flit  = in_flit[w_sel];
   assign cur_grant = w_sel;
   assign w_xfer    = out_valid && out_ready;
   assign w_done    = w_xfer && in_last[w_sel];
   assign w_wsel    = weight[w_sel*WW +: WW];

   always_comb begin
      in_ready = '0;
      if (out_ready && in_valid[w_sel]) in_ready[w_sel] = 1'b1;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_owner_nxt  = r_owner;
      w_credit_nxt = r_credit;
      if (w_xfer) begin
         if (!in_last[w_sel]) begin
            if (r_state == ARB) begin
               w_state_nxt = LOCK;
               w_owner_nxt = w_sel;
            end
         end else begin
            w_state_nxt = ARB;
            if (w_sel != r_ptr) begin
               w_ptr_nxt    = w_sel;
               w_credit_nxt = (w_wsel == '0) ? '0 : w_wsel - WW'(1);
            end else if (r_credit != '0) begin
               w_credit_nxt = r_credit - WW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ARB;
         r_ptr    <= '0;
         r_owner  <= '0;
         r_credit <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_owner  <= w_owner_nxt;
         r_credit <= w_credit_nxt;
      end
   end

   // Clear takes priority over a same-cycle completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_IN; i++) r_stat[i] <= '0;
      end else if (stat_clr) begin
         for (int i = 0; i < N_IN; i++) r_stat[i] <= '0;
      end else if (w_done && (r_stat[w_sel] != '1)) begin
         r_stat[w_sel] <= r_stat[w_sel] + CW'(1);
      end
   end

   for (genvar g = 0; g < N_IN; g++) begin : g_stat
      assign stat_cnt[g*CW +: CW] = r_stat[g];
   end

endmodule
